// File: rtl/argmax.sv
// Streaming argmax for the classifier output stage.
// After an arming edge (start in IDLE) the block accepts N signed scores,
// one per in_valid cycle, and reports the index of the first maximum with a
// one-cycle done pulse. max_index only changes on the edge that accepts the
// last score, so it stays stable for the whole of the following run.
module argmax #(
    parameter int N      = 10,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic [IDX_W-1:0]         max_index,
    output logic                     done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state;
    logic [IDX_W-1:0]           count;
    logic signed [DATA_W-1:0]   best_val;
    logic [IDX_W-1:0]           best_idx;

    logic                       take;
    logic                       last;
    logic [IDX_W-1:0]           win_idx;

    // Sample 0 always wins; later samples must be strictly greater (signed),
    // so ties keep the lower index.
    assign take    = (count == '0) || (in_data > best_val);
    assign last    = (count == IDX_W'(N - 1));
    // Winner including the sample being accepted now, used on the final edge.
    assign win_idx = take ? count : best_idx;

    // Control FSM plus running-max datapath with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            max_index <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // in_valid is ignored here; only start matters.
                    if (start) begin
                        state    <= ST_RUN;
                        count    <= '0;
                        best_val <= '0;
                        best_idx <= '0;
                    end
                end
                ST_RUN: begin
                    // in_valid low is a stall: nothing changes.
                    if (in_valid) begin
                        if (take) begin
                            best_val <= in_data;
                            best_idx <= count;
                        end
                        count <= count + IDX_W'(1);
                        if (last) begin
                            max_index <= win_idx;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Single-cycle done; start is re-evaluated once back in IDLE.
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax.sv
// Directed bench for argmax: expected winners are queued when a run is
// driven and popped when the DUT raises done.
module tb_argmax;

    typedef logic signed [15:0] score_t;

    logic             clk;
    logic             reset;
    logic             start;
    score_t           in_data;
    logic             in_valid;
    logic [3:0]       max_index;
    logic             done;

    int checks;
    int failures;
    int q[$];
    int pushes;
    int done_seen;
    int cyc;
    int last_done_cyc;
    int prev_done_cyc;
    int prev;

    score_t basic  [10];
    score_t negs   [10];
    score_t first  [10];
    score_t lastv  [10];
    score_t zeros  [10];

    argmax #(.N(10), .DATA_W(16), .IDX_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .max_index (max_index),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent reference: first index holding the largest signed value.
    function automatic int ref_argmax(input score_t v[10]);
        int best;
        best = 0;
        for (int i = 1; i < 10; i++)
            if (v[i] > v[best]) best = i;
        return best;
    endfunction

    function automatic logic start_level(input int mode, input int i);
        if (mode == 1) return 1'b1;
        if (mode == 2) return i[0];
        return 1'b0;
    endfunction

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic step(input logic s, input logic v, input score_t d);
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_seen++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            check("done_has_expectation", (q.size() != 0), 1);
            if (q.size() != 0) check("max_index", max_index, q.pop_front());
            $display("done at cycle %0d max_index=%0d", cyc, max_index);
        end
    endtask

    // Full run from IDLE. stall_at: sample index preceded by 3 idle cycles
    // (-1 for none). mode: 0 start low, 1 start held high, 2 start toggling.
    task automatic run(input string name, input score_t v[10], input int stall_at, input int mode);
        int exp;
        exp = ref_argmax(v);
        q.push_back(exp);
        pushes++;
        $display("run %s expected index %0d", name, exp);
        // Arming edge with a large valid score that must not be captured.
        step(1'b1, 1'b1, 16'sd30000);
        check("arm_no_done", done, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == stall_at) begin
                for (int j = 0; j < 3; j++) begin
                    step(start_level(mode, i), 1'b0, 16'sh7fff);
                    check("stall_no_done", done, 0);
                end
            end
            step(start_level(mode, i), 1'b1, v[i]);
            if (i < 9) begin
                check("no_early_done", done, 0);
                check("index_hold", max_index, prev);
            end
        end
        check("done_pulse", done, 1);
        prev = exp;
        step(mode == 1, 1'b0, 16'sd0);
        check("done_one_cycle", done, 0);
        check("index_after_run", max_index, exp);
    endtask

    initial begin
        checks = 0; failures = 0; pushes = 0; done_seen = 0;
        cyc = 0; last_done_cyc = 0; prev_done_cyc = 0; prev = 0;
        basic = '{16'sd100, -16'sd50, 16'sd200, 16'sd500, 16'sd123,
                  -16'sd300, 16'sd250, 16'sd4000, 16'sd50, 16'sd10};
        negs  = '{-16'sd5, -16'sd3, -16'sd3, -16'sd9, -16'sd3,
                  -16'sd100, -16'sd7, -16'sd4, -16'sd3, -16'sd8};
        first = '{16'sh7fff, -16'sd50, 16'sd200, 16'sd500, 16'sd123,
                  -16'sd300, 16'sd250, 16'sd4000, 16'sd50, 16'sd10};
        for (int i = 0; i < 9; i++) lastv[i] = 16'sh8000;
        lastv[9] = 16'sd1;
        for (int i = 0; i < 10; i++) zeros[i] = 16'sd0;

        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", done, 0);
        check("reset_index", max_index, 0);
        reset = 1'b1;

        run("basic", basic, -1, 1);
        run("all_negative_ties", negs, -1, 0);
        run("basic_stalled", basic, 5, 0);
        run("max_first", first, -1, 0);
        run("max_last", lastv, -1, 0);

        // Stray valid samples in IDLE, then a run with start toggling.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'sd30000);
            check("idle_no_done", done, 0);
            check("idle_index_hold", max_index, prev);
        end
        run("basic_start_toggle", basic, -1, 2);

        // Reset mid-run: outputs must clear without a clock edge.
        $display("reset mid-run after 5 samples");
        step(1'b1, 1'b0, 16'sd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, basic[i]);
        #2 reset = 1'b0;
        #1;
        check("async_reset_done", done, 0);
        check("async_reset_index", max_index, 0);
        step(1'b0, 1'b0, 16'sd0);
        step(1'b0, 1'b0, 16'sd0);
        reset = 1'b1;
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 16'sd1000);
            check("abandoned_no_done", done, 0);
        end
        run("after_reset", basic, -1, 0);

        // Back-to-back runs with start held high between them.
        run("b2b_basic", basic, -1, 1);
        run("b2b_zeros", zeros, -1, 0);
        check("done_gap_cycles", last_done_cyc - prev_done_cyc, 12);

        step(1'b0, 1'b0, 16'sd0);
        check("done_count", done_seen, pushes);
        check("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/argmax.md
# argmax

Streaming argmax unit for the classifier output stage: after `start`, it accepts N signed scores one per valid cycle and reports the index of the largest. It sits after the final dense layer and produces the predicted class (0–9 for the default N=10) with a one-cycle `done` pulse.

## Interface
- `N`, default 10: number of scores per inference.
- `DATA_W`, default 16: score width, two's-complement signed.
- `IDX_W`, default 4: index width; must satisfy 2^IDX_W ≥ N.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled only in IDLE, where it arms a new run.
- `in_data`  in  DATA_W  signed score; sampled when `in_valid`=1 in RUN.
- `in_valid`  in  1  qualifies `in_data`.
- `max_index`  out  IDX_W  index (0..N-1) of the maximum score of the last completed run.
- `done`  out  1  one-cycle pulse marking `max_index` final.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_valid` is ignored. If `start`=1 at a rising edge, go to RUN, clear the sample counter and clear the running max.
- RUN: at each edge with `in_valid`=1, accept `in_data` as sample number `count`, then increment `count`. `in_valid`=0 stalls with no state change. `start` is ignored.
- Sample 0 always loads `best_val`=`in_data` and `best_idx`=0.
- Sample k>0 replaces the best only if `in_data` > `best_val` under a signed DATA_W compare. Ties keep the earlier (lower) index.
- On the edge that accepts sample N-1:
  - `max_index` gets the final winner, including sample N-1 if it wins.
  - `done` is set to 1.
  - State goes to DONE.
- DONE: at the next edge, `done` returns to 0 and state goes to IDLE. `in_valid` is ignored.
- If `start` is still high in IDLE, a new run arms immediately.
- `max_index` holds its value until the final edge of the next run. It is not updated while a run is in progress.
- Counter width is IDX_W. No wrap is possible because the run ends at N.
- Reset asserted (low) at any time forces, asynchronously:
  - state IDLE
  - `done`=0, `max_index`=0
  - `count`=0, `best_val`=0, `best_idx`=0
- After reset is released, a run in progress is abandoned and a new `start` is required.

## Timing
- Reset values: `done`=0, `max_index`=0.
- `start` sampled at edge E puts the block in RUN after E. The earliest sample accepted is at edge E+1. Data presented in the same cycle as the arming edge is not captured.
- Throughput is one sample per clock. With back-to-back valid samples, N samples occupy N consecutive edges.
- Latency: `done` and the final `max_index` are registered outputs, valid in the cycle directly after the edge accepting sample N-1. `done` is high for exactly one cycle.
- Minimum cycle-to-cycle run period is N+2 edges: arm, N samples, DONE.
- No combinational path from any input to any output.

## Test plan
- Basic: reset, release, hold `start`=1, then stream 100, -50, 200, 500, 123, -300, 250, 4000, 50, 10 on consecutive cycles. Required: `max_index`=7 with `done`=1 for exactly one cycle, on the cycle after the 10th sample.
- All negative and ties: stream -5, -3, -3, -9, -3, -100, -7, -4, -3, -8. Required: `max_index`=1 (first of the tied maxima; a signed compare is required).
- Stalls and edges: same data as Basic with `in_valid` deasserted for 3 cycles between samples 4 and 5. Then a run with the max at index 0 (32767 first) and one with the max at index 9 (-32768 everywhere else, 1 last). Required: results 7, 0, 9 respectively. `done` is never asserted early.
- Ignored inputs: pulse `in_valid` with value 30000 while in IDLE, then run the Basic data. Toggle `start` mid-run. Required: `max_index`=7. Stray samples and mid-run `start` have no effect.
- Reset mid-run: assert `reset` low after 5 samples. Required: `done`=0 and `max_index`=0 immediately, without waiting for a clock edge. A fresh full run afterwards gives the correct index.
- Back-to-back: keep `start` high for two runs (Basic data, then all values equal to 0). Required: results 7 then 0. Two `done` pulses separated by N+1 cycles of low. `max_index` holds 7 during the second run.
